// File: rtl/div_top_if.sv
// rtl/div_top_if.sv - start/done handshake and result bundle for the 32-by-16 divider
interface div_top_if;
    logic        start;
    logic [31:0] p;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [15:0] r;
    logic        ovf;
    logic        dz;

    modport master (
        output start, p, y,
        input  busy, done, q, r, ovf, dz
    );

    modport slave (
        input  start, p, y,
        output busy, done, q, r, ovf, dz
    );
endinterface

// File: rtl/div_top.sv
// rtl/div_top.sv - sequential 32-by-16 unsigned restoring divider, one quotient bit per cycle
module div_top (
    input  logic      clk,
    input  logic      rst,
    div_top_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Dividend shift register; quotient bits shift in from the bottom as the
    // dividend bits leave the top, so after 32 steps it holds the quotient.
    logic [31:0] r_dvd;
    logic [15:0] r_div;
    logic [15:0] r_rem;
    logic [4:0]  r_cnt;

    logic [31:0] r_q;
    logic [15:0] r_r;
    logic        r_ovf;
    logic        r_dz;

    logic        w_accept;
    logic        w_busy;
    logic        w_done;
    logic        w_last;
    logic        w_ge;
    logic [16:0] w_rem_sh;
    logic [15:0] w_rem_nxt;
    logic [31:0] w_dvd_nxt;

    // One restoring step: 17-bit shifted remainder so y >= 0x8000 loses no carry.
    // The remainder stays below the divisor, so 16 bits hold it between steps.
    assign w_rem_sh  = {r_rem, r_dvd[31]};
    assign w_ge      = (w_rem_sh >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? 16'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[15:0];
    assign w_dvd_nxt = {r_dvd[30:0], w_ge};
    assign w_last    = (r_cnt == 5'd31);

    // State register; reset aborts any divide in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; a zero divisor skips the iteration.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.y == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.y == 16'd0) ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, iteration, and result registers that only move on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= '0;
            r_div <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            r_q   <= '0;
            r_r   <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= bus.p;
            r_div <= bus.y;
            r_rem <= '0;
            r_cnt <= '0;
            if (bus.y == 16'd0) begin
                r_q   <= '1;
                r_r   <= bus.p[15:0];
                r_ovf <= 1'b0;
                r_dz  <= 1'b1;
            end
        end else if (w_busy) begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + 5'd1;
            if (w_last) begin
                r_q   <= w_dvd_nxt;
                r_r   <= w_rem_nxt;
                r_ovf <= |w_dvd_nxt[31:16];
                r_dz  <= 1'b0;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.ovf  = r_ovf;
    assign bus.dz   = r_dz;

endmodule

// File: doc/div_top.md
# div_top

Sequential 32-by-16 unsigned divider: the inverse of the team's 16x16 multiplier top. It accepts a 32-bit product-sized dividend and a 16-bit divisor, and computes the quotient and remainder with a radix-2 restoring algorithm, one quotient bit per cycle. It sits wherever a multiplier result must be divided back down, for example to recover one operand from a product. It uses a start/done handshake with a busy indicator.

## Interface

Parameters: none. Widths are fixed at 32/16 to match the multiplier.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- p  input  32  dividend; sampled on the cycle start is accepted.
- y  input  16  divisor; sampled on the cycle start is accepted.
- busy  output  1  high while an iteration sequence is running (RUN state).
- done  output  1  single-cycle pulse: q, r and the flags are valid.
- q  output  32  quotient, floor(p/y).
- r  output  16  remainder, p mod y.
- ovf  output  1  set when q > 0xFFFF, i.e. the quotient is not a valid 16-bit multiplier operand.
- dz  output  1  set when the divisor is zero.

## Operation

- State machine: IDLE, RUN, DONE.
- IDLE: if start=1, latch p into the dividend shift register and y into the divisor register, and clear the partial remainder and the iteration counter.
  - If y==0, go to DONE.
  - Otherwise go to RUN.
- RUN, one step per cycle:
  - Form rem_sh = {rem[15:0], dvd[31]} at 17 bits and shift dvd left by 1.
  - If rem_sh >= {1'b0, y}: rem = rem_sh - y and shift quotient bit 1 into q.
  - Otherwise rem = rem_sh and shift in 0.
  - After 32 steps (counter 0..31), go to DONE.
- DONE: done=1 for exactly one cycle. If start=1 in this cycle, accept the new operands exactly as in IDLE; otherwise return to IDLE.
- Divide by zero: q=0xFFFFFFFF, r=p[15:0], dz=1, ovf=0.
- Normal completion: dz=0 and ovf=|q[31:16].
- q, r, ovf and dz update only when done is asserted and hold their values until the next completion. They do not change while RUN is in progress.
- start in RUN is ignored. p and y are don't-care outside the accept cycle.
- Remainder datapath is 17 bits, so no carry is lost when y >= 0x8000. r is always < y.

## Timing

- Reset (rst=1 at a clock edge) forces IDLE regardless of the current state and aborts any operation in progress.
  - Outputs after reset: busy=0, done=0, q=0, r=0, ovf=0, dz=0.
  - The first start is accepted on the first clock edge at which rst=0.
- start accepted at edge E0, normal divisor:
  - busy=1 during the 32 cycles after E0.
  - done=1, with valid results, in the cycle after the 32nd RUN step.
  - Total latency: 33 cycles from the accepting edge to done, i.e. done is high in cycle E0+33.
- Divide by zero: done=1 in the cycle immediately after E0 (latency 1), and busy stays 0.
- Back-to-back operation: start held high through DONE gives one result every 33 cycles, with no IDLE gap.
- Reset and start both asserted at the same edge: reset wins and the start is dropped.

## Test plan

- p=100, y=7, pulse start -> done exactly 33 cycles later; q=14, r=2, ovf=0, dz=0; busy high for exactly 32 cycles.
- p=0xFFFE0001, y=0xFFFF -> q=0x0000FFFF, r=0, ovf=0. Also p=0xFFFFFFFF, y=0x8001 -> q=0x0001FFFC, r=0x0003, ovf=1 (checks the 17-bit remainder path).
- p=0x12345678, y=0 -> done one cycle after start; busy never rises; q=0xFFFFFFFF, r=0x5678, dz=1, ovf=0.
- Random p and y loop over 10k ops, with start held high for back-to-back operation -> every result satisfies q*y+r==p and r<y; done spacing is 33 cycles; start pulses injected during RUN have no effect.
- rst asserted at step 10 of a running divide -> next cycle busy=0, done=0, q=r=0, flags=0. A new start (p=81, y=9) then completes normally with q=9, r=0.
- Multiplier round-trip: x=0xBEEF and y=0x1234 through the multiplier, product fed to div_top with y=0x1234 -> q=0x0000BEEF, r=0, ovf=0.
